// File: rtl/signeddiv_if.sv
// signeddiv_if: operand/result handshake bundle for the signed Q3.12 divider
interface signeddiv_if;
    logic [15:0] a;
    logic [15:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] c;
    logic        ovf;
    logic        dz;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output a, b, in_valid, out_ready,
        input  in_ready, c, ovf, dz, out_valid
    );

    modport slave (
        input  a, b, in_valid, out_ready,
        output in_ready, c, ovf, dz, out_valid
    );
endinterface

// File: rtl/signeddiv.sv
// signeddiv: sequential signed Q3.12 divider, radix-2 restoring on magnitudes; define DIV_SATURATE_EN to clamp overflowing quotients to +/-0x7FFF
module signeddiv (
    input  logic       clk,
    input  logic       rst,
    signeddiv_if.slave bus
);
    localparam int WIDTH = 16;
    localparam int FRAC  = 12;
    localparam int ITER  = WIDTH + FRAC;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [ITER-1:0]  dvd_q, dvd_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             sign_q, sign_d;
    logic             dzf_q, dzf_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] a_mag, b_mag, mag;
    logic [WIDTH:0]   trial;
    logic             ge, q_ovf;

    // 0x8000 maps to 32768, which still fits the unsigned 16-bit magnitude
    assign a_mag = bus.a[WIDTH-1] ? ~bus.a + 1'b1 : bus.a;
    assign b_mag = bus.b[WIDTH-1] ? ~bus.b + 1'b1 : bus.b;

    // dvd_q shifts dividend bits out of its MSB while quotient bits enter at its LSB
    assign trial = {rem_q, dvd_q[ITER-1]};
    assign ge    = trial >= {1'b0, div_q};
    assign q_ovf = (|dvd_q[ITER-1:WIDTH-1]) | dzf_q;

`ifdef DIV_SATURATE_EN
    assign mag = q_ovf ? 16'h7FFF : {1'b0, dvd_q[WIDTH-2:0]};
`else
    assign mag = dzf_q ? 16'h7FFF : {1'b0, dvd_q[WIDTH-2:0]};
`endif

    // accept operands, run ITER restoring steps, form the signed result, hold it until consumed
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        div_d   = div_q;
        sign_d  = sign_q;
        dzf_d   = dzf_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                div_d   = b_mag;
                dvd_d   = {a_mag, {FRAC{1'b0}}};
                rem_d   = '0;
                cnt_d   = '0;
                sign_d  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                dzf_d   = bus.b == '0;
                state_d = CALC;
            end
            CALC: if (cnt_q == 5'(ITER)) begin
                c_d     = sign_q ? ~mag + 1'b1 : mag;
                ovf_d   = q_ovf;
                dz_d    = dzf_q;
                state_d = DONE;
            end else begin
                rem_d = ge ? WIDTH'(trial - {1'b0, div_q}) : trial[WIDTH-1:0];
                dvd_d = {dvd_q[ITER-2:0], ge};
                cnt_d = cnt_q + 5'd1;
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            sign_q  <= 1'b0;
            dzf_q   <= 1'b0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            sign_q  <= sign_d;
            dzf_q   <= dzf_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.c         = c_q;
    assign bus.ovf       = ovf_q;
    assign bus.dz        = dz_q;
endmodule

// File: tb/tb_signeddiv.sv
// tb_signeddiv: randomized and directed checks of signeddiv against an arithmetic reference model
module tb_signeddiv;
    logic clk;
    logic rst;
    int   total;
    int   passed;
    int   lat;

    signeddiv_if bus();

    signeddiv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // expected {dz, ovf, c} from plain integer arithmetic on Q3.12 values
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b);
        longint ma, mb, q, mag;
        logic   s, ov;
        ma = a[15] ? 65536 - longint'(a) : longint'(a);
        mb = b[15] ? 65536 - longint'(b) : longint'(b);
        s  = a[15] ^ b[15];
        if (b == 16'h0) begin
            mag = 32767;
            ov  = 1'b1;
        end else begin
            q  = (ma * 4096) / mb;
            ov = q > 32767;
`ifdef DIV_SATURATE_EN
            mag = ov ? 32767 : q;
`else
            mag = q % 32768;
`endif
        end
        return {b == 16'h0, ov, s ? 16'((65536 - mag) % 65536) : 16'(mag)};
    endfunction

    // present operands at a negedge, count edges after the accepting edge until out_valid
    task automatic run_op(input logic [15:0] a, input logic [15:0] b);
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.out_valid) break;
        end
    endtask

    task automatic test_reset;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.c, bus.ovf, bus.dz} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
            $display("FAIL reset: rdy=%b vld=%b c=%h ovf=%b dz=%b, want rdy=1 vld=0 c=0000 ovf=0 dz=0",
                     bus.in_ready, bus.out_valid, bus.c, bus.ovf, bus.dz);
        end else passed++;
    endtask

    task automatic test_directed;
        logic [15:0] av[10] = '{16'h1000, 16'hF000, 16'h1000, 16'h7000, 16'h1000,
                                16'h9000, 16'h8000, 16'h0000, 16'hFFFF, 16'h7FFF};
        logic [15:0] bv[10] = '{16'h2000, 16'h0800, 16'h3000, 16'h0400, 16'h0000,
                                16'h0000, 16'h1000, 16'h1234, 16'h0001, 16'h8000};
        logic [17:0] exp;
        for (int i = 0; i < 10; i++) begin
            exp = model(av[i], bv[i]);
            run_op(av[i], bv[i]);
            total++;
            if (lat !== 29) $display("FAIL latency[%0d]: got %0d want 29", i, lat);
            else passed++;
            total++;
            if ({bus.dz, bus.ovf, bus.c} !== exp)
                $display("FAIL directed[%0d] a=%h b=%h: got dz=%b ovf=%b c=%h want dz=%b ovf=%b c=%h",
                         i, av[i], bv[i], bus.dz, bus.ovf, bus.c, exp[17], exp[16], exp[15:0]);
            else passed++;
            @(posedge clk);
            @(negedge clk);
            total++;
            if ({bus.in_ready, bus.out_valid, bus.c} !== {1'b1, 1'b0, exp[15:0]})
                $display("FAIL post_handshake[%0d]: rdy=%b vld=%b c=%h want rdy=1 vld=0 c=%h",
                         i, bus.in_ready, bus.out_valid, bus.c, exp[15:0]);
            else passed++;
        end
    endtask

    task automatic test_random;
        logic [15:0] a, b;
        logic [17:0] exp;
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            exp = model(a, b);
            run_op(a, b);
            total++;
            if (lat !== 29 || {bus.dz, bus.ovf, bus.c} !== exp)
                $display("FAIL random[%0d] a=%h b=%h: got lat=%0d dz=%b ovf=%b c=%h want lat=29 dz=%b ovf=%b c=%h",
                         i, a, b, lat, bus.dz, bus.ovf, bus.c, exp[17], exp[16], exp[15:0]);
            else passed++;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] held;
        logic [17:0] exp;
        bus.out_ready = 1'b0;
        run_op(16'h1000, 16'h2000);
        held = bus.c;
        total++;
        if (held !== 16'h0800) $display("FAIL bp_result: got c=%h want 0800", held);
        else passed++;
        bus.a = 16'h3000;
        bus.b = 16'h1000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if ({bus.out_valid, bus.in_ready, bus.c} !== {1'b1, 1'b0, held})
                $display("FAIL bp_hold[%0d]: vld=%b rdy=%b c=%h want vld=1 rdy=0 c=%h",
                         i, bus.out_valid, bus.in_ready, bus.c, held);
            else passed++;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10)
            $display("FAIL bp_release: rdy=%b vld=%b want rdy=1 vld=0", bus.in_ready, bus.out_valid);
        else passed++;
        exp = model(16'h3000, 16'h1000);
        run_op(16'h3000, 16'h1000);
        total++;
        if (lat !== 29 || {bus.dz, bus.ovf, bus.c} !== exp)
            $display("FAIL bp_next: got lat=%0d c=%h ovf=%b dz=%b want lat=29 c=%h ovf=%b dz=%b",
                     lat, bus.c, bus.ovf, bus.dz, exp[15:0], exp[16], exp[17]);
        else passed++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        bus.a = 16'h7000;
        bus.b = 16'h0300;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.c, bus.ovf, bus.dz} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0})
            $display("FAIL abort_reset: rdy=%b vld=%b c=%h ovf=%b dz=%b want rdy=1 vld=0 c=0000 ovf=0 dz=0",
                     bus.in_ready, bus.out_valid, bus.c, bus.ovf, bus.dz);
        else passed++;
        run_op(16'h2000, 16'h1000);
        total++;
        if (lat !== 29 || {bus.dz, bus.ovf, bus.c} !== {1'b0, 1'b0, 16'h2000})
            $display("FAIL abort_fresh: got lat=%0d c=%h ovf=%b dz=%b want lat=29 c=2000 ovf=0 dz=0",
                     lat, bus.c, bus.ovf, bus.dz);
        else passed++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        total = 0;
        passed = 0;
        bus.a = '0;
        bus.b = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
